// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block-in / word-out handshake bundle for the SHA-256 message schedule
interface sha256_msg_schedule_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round_out;
    logic         w_last;

    modport slave (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_out, k_out, round_out, w_last
    );

    modport master (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_out, k_out, round_out, w_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule, 16-word sliding window emitting W_t/K_t per round
// Optional macro SHA256_SCHED_OVERLAP_EN: accept the next block on the final word for zero-bubble streaming.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sha256_msg_schedule_if.slave      bus
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    logic        last_word;
    logic        blk_ready_c;
    logic        blk_hs;
    logic        w_hs;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    always_comb begin
        last_word = (state_q == RUN) && (t_q == LAST_T);
`ifdef SHA256_SCHED_OVERLAP_EN
        blk_ready_c = (state_q == IDLE) || (last_word && bus.w_ready);
`else
        blk_ready_c = (state_q == IDLE);
`endif
        w_hs   = (state_q == RUN) && bus.w_ready;
        blk_hs = bus.blk_valid && blk_ready_c;
        // 32-bit sum wraps naturally; carries out of bit 31 are dropped
        w_new  = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;

        // a block load takes priority over the final shift when blocks overlap
        if (blk_hs) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = bus.blk_data[511 - 32*i -: 32];
            end
            t_d     = 6'd0;
            state_d = RUN;
        end else if (w_hs) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[15] = w_new;
            t_d       = t_q + 6'd1;
            if (last_word) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign bus.blk_ready = blk_ready_c;
    assign bus.w_valid   = (state_q == RUN);
    assign bus.w_out     = win_q[0];
    assign bus.k_out     = K_TABLE[t_q];
    assign bus.round_out = t_q;
    assign bus.w_last    = last_word;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed vector bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic clk;
    logic rst_n;
    sha256_msg_schedule_if bus ();

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SHA256_SCHED_OVERLAP_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif

    localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ONES_BLK = {512{1'b1}};

    typedef struct {
        string       name;
        int          round;
        bit          chk_w;
        logic [31:0] w;
        logic [31:0] k;
        logic        last;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w   [64];
    logic [31:0] got_w   [64];
    logic [31:0] got_k   [64];
    logic [5:0]  got_r   [64];
    logic        got_l   [64];
    logic [31:0] ref_w   [64];
    logic [31:0] b2b_w   [128];
    logic [5:0]  b2b_r   [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference expansion in the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] form
    task automatic model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
        end
    endtask

    function automatic int seq_diff();
        int d = 0;
        for (int i = 0; i < 64; i++) begin
            if (got_w[i] !== exp_w[i] || got_r[i] !== 6'(i) || got_l[i] !== (i == 63)) d++;
        end
        return d;
    endfunction

    task automatic run_block(input logic [511:0] blk, input bit bp, input int pulse_round,
                             input int stop_round, output int n, output int cycles,
                             output int stall_bad, output logic rdy_at_pulse);
        int          g;
        bit          held, pulsed;
        logic [31:0] hw, hk;
        logic [5:0]  hr;
        logic        hl;
        n = 0; cycles = 0; stall_bad = 0; rdy_at_pulse = 1'bx;
        held = 0; pulsed = 0; hw = 0; hk = 0; hr = 0; hl = 0;
        @(negedge clk);
        bus.blk_data  = blk;
        bus.blk_valid = 1'b1;
        bus.w_ready   = 1'b1;
        #1;
        g = 0;
        while (!bus.blk_ready && g < 200) begin
            @(negedge clk); #1; g++;
        end
        if (!bus.blk_ready) begin
            chk("blk_accept_timeout", 32'(bus.blk_ready), 32'd1);
            bus.blk_valid = 1'b0;
            return;
        end
        while (n < 64 && cycles < 1000) begin
            @(negedge clk);
            bus.blk_valid = 1'b0;
            if (bus.w_valid && bus.round_out == 6'(pulse_round) && !pulsed) begin
                bus.blk_valid = 1'b1;
                bus.blk_data  = ONES_BLK;
            end
            bus.w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.blk_valid) begin
                rdy_at_pulse = bus.blk_ready;
                pulsed = 1;
            end
            if (held && (bus.w_out !== hw || bus.k_out !== hk || bus.round_out !== hr ||
                         bus.w_last !== hl || !bus.w_valid)) stall_bad++;
            if (stop_round >= 0 && bus.w_valid && bus.round_out == 6'(stop_round)) return;
            if (bus.w_valid && bus.w_ready) begin
                got_w[n] = bus.w_out;
                got_k[n] = bus.k_out;
                got_r[n] = bus.round_out;
                got_l[n] = bus.w_last;
                n++;
            end
            held = bus.w_valid && !bus.w_ready;
            hw = bus.w_out; hk = bus.k_out; hr = bus.round_out; hl = bus.w_last;
            cycles++;
        end
        @(negedge clk);
        bus.blk_valid = 1'b0;
        bus.w_ready   = 1'b1;
    endtask

    initial begin
        vec_t        vecs [5];
        int          n, cyc, sbad, gap, acc, nb;
        logic        rdy;
        logic [31:0] exp_a [64];
        logic [31:0] exp_b [64];
        bit          seen_last, nxt_b, nxt_drop;

        vecs[0] = '{"abc_r0",  0,  1'b1, 32'h61626380, 32'h428a2f98, 1'b0};
        vecs[1] = '{"abc_r15", 15, 1'b1, 32'h00000018, 32'hc19bf174, 1'b0};
        vecs[2] = '{"abc_r16", 16, 1'b1, 32'h61626380, 32'he49b69c1, 1'b0};
        vecs[3] = '{"abc_r17", 17, 1'b1, 32'h000F0000, 32'hefbe4786, 1'b0};
        vecs[4] = '{"abc_r63", 63, 1'b0, 32'h0,        32'hc67178f2, 1'b1};

        rst_n = 1'b0;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_blk_ready", 32'(bus.blk_ready), 32'd1);
        chk("rst_w_valid",   32'(bus.w_valid),   32'd0);
        chk("rst_w_last",    32'(bus.w_last),    32'd0);
        chk("rst_w_out",     bus.w_out,          32'd0);
        chk("rst_round_out", 32'(bus.round_out), 32'd0);
        chk("rst_k_out",     bus.k_out,          32'h428a2f98);
        rst_n = 1'b1;

        // "abc" block, no backpressure
        model(ABC_BLK);
        run_block(ABC_BLK, 1'b0, -1, -1, n, cyc, sbad, rdy);
        chk("abc_count", 32'(n), 32'd64);
        chk("abc_cycles", 32'(cyc), 32'd64);
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].chk_w) chk({vecs[i].name, "_w"}, got_w[vecs[i].round], vecs[i].w);
            chk({vecs[i].name, "_k"}, got_k[vecs[i].round], vecs[i].k);
            chk({vecs[i].name, "_last"}, 32'(got_l[vecs[i].round]), 32'(vecs[i].last));
        end
        chk("abc_seq_diffs", 32'(seq_diff()), 32'd0);
        ref_w = got_w;
        chk("abc_idle_after", 32'(bus.w_valid), 32'd0);

        // all-ones block exercises the modulo-2^32 wrap
        model(ONES_BLK);
        run_block(ONES_BLK, 1'b0, -1, -1, n, cyc, sbad, rdy);
        chk("ones_w16", got_w[16], 32'h203FFFFC);
        chk("ones_seq_diffs", 32'(seq_diff()), 32'd0);

        // backpressure on "abc"
        model(ABC_BLK);
        run_block(ABC_BLK, 1'b1, -1, -1, n, cyc, sbad, rdy);
        chk("bp_count", 32'(n), 32'd64);
        chk("bp_stall_changes", 32'(sbad), 32'd0);
        nb = 0;
        for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i]) nb++;
        chk("bp_vs_nostall_diffs", 32'(nb), 32'd0);

        // blk_valid pulsed mid-block must be refused and ignored
        run_block(ABC_BLK, 1'b0, 10, -1, n, cyc, sbad, rdy);
        chk("ign_blk_ready", 32'(rdy), 32'd0);
        chk("ign_seq_diffs", 32'(seq_diff()), 32'd0);
        chk("ign_idle_after", 32'(bus.w_valid), 32'd0);

        // back-to-back: abc then all-ones offered continuously
        model(ABC_BLK);  exp_a = exp_w;
        model(ONES_BLK); exp_b = exp_w;
        @(negedge clk);
        bus.blk_data = ABC_BLK; bus.blk_valid = 1'b1; bus.w_ready = 1'b1;
        n = 0; cyc = 0; gap = 0; acc = 0; seen_last = 0; nxt_b = 0; nxt_drop = 0;
        while (n < 128 && cyc < 500) begin
            if (cyc > 0) @(negedge clk);
            if (nxt_b) begin bus.blk_data = ONES_BLK; nxt_b = 0; end
            if (nxt_drop) begin bus.blk_valid = 1'b0; nxt_drop = 0; end
            #1;
            if (bus.blk_valid && bus.blk_ready) begin
                acc++;
                if (acc == 1) nxt_b = 1;
                else nxt_drop = 1;
            end
            if (bus.w_valid && bus.w_ready) begin
                b2b_w[n] = bus.w_out;
                b2b_r[n] = bus.round_out;
                if (n == 63) seen_last = 1;
                n++;
            end else if (!bus.w_valid && seen_last && n == 64) begin
                gap++;
            end
            cyc++;
        end
        bus.blk_valid = 1'b0;
        chk("b2b_count", 32'(n), 32'd128);
        chk("b2b_gap", 32'(gap), 32'(EXP_GAP));
        nb = 0;
        for (int i = 0; i < 64; i++) begin
            if (b2b_w[i] !== exp_a[i] || b2b_r[i] !== 6'(i)) nb++;
            if (b2b_w[64+i] !== exp_b[i] || b2b_r[64+i] !== 6'(i)) nb++;
        end
        chk("b2b_seq_diffs", 32'(nb), 32'd0);
        repeat (2) @(negedge clk);

        // asynchronous reset at round 30
        run_block(ABC_BLK, 1'b0, -1, 30, n, cyc, sbad, rdy);
        chk("pre_rst_round", 32'(bus.round_out), 32'd30);
        rst_n = 1'b0;
        #1;
        chk("arst_w_valid",   32'(bus.w_valid),   32'd0);
        chk("arst_blk_ready", 32'(bus.blk_ready), 32'd1);
        chk("arst_round_out", 32'(bus.round_out), 32'd0);
        chk("arst_w_out",     bus.w_out,          32'd0);
        chk("arst_k_out",     bus.k_out,          32'h428a2f98);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model(ABC_BLK);
        run_block(ABC_BLK, 1'b0, -1, -1, n, cyc, sbad, rdy);
        chk("post_rst_round0", 32'(got_r[0]), 32'd0);
        chk("post_rst_seq_diffs", 32'(seq_diff()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
